// File: rtl/shift_pla_atanh.sv
// Inverse shift-PLA tanh: x ~= atanh(y) from a leading-zero scan of z = 1-|y|; latency L+3 cycles (L = shifts, 0..2*SAT_K).
// One operand in flight; in_ready is low from accept until the result is taken, out_valid holds until out_ready.
module shift_pla_atanh #(
  parameter int W_IN  = 16,
  parameter int W_OUT = 16,
  parameter int OUT_I = 4,
  parameter int SAT_K = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [W_IN-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W_OUT-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sat
);

  localparam int F     = W_IN - 1;
  localparam int OUT_F = W_OUT - OUT_I;
  localparam int LIM   = 2 * SAT_K;
  localparam int LW    = $clog2(LIM + 1);
  localparam int SH    = W_IN - OUT_F;
  localparam int NW    = W_IN + LW;

  localparam logic [W_IN-1:0]  ONE     = {1'b1, {F{1'b0}}};
  localparam logic [LW-1:0]    LIM_L   = (LW)'(LIM);
  localparam logic [W_OUT-1:0] POS_MAX = {1'b0, {(W_OUT-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, NORM, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [W_IN-1:0]  z_q, z_d;
  logic [LW-1:0]    l_q, l_d;
  logic             sign_q, sign_d;
  logic [W_OUT-1:0] data_q, data_d;
  logic             sat_q, sat_d;

  logic [W_IN-1:0]  abs_y;
  logic             z_zero;
  logic             sat_c;
  logic [NW-1:0]    num;
  logic [NW-1:0]    mag_full;
  logic             over;
  logic [W_OUT-1:0] mag;

  always_comb begin
    abs_y    = in_data[W_IN-1] ? -in_data : in_data;
    z_zero   = (z_q == '0);
    sat_c    = z_zero || (l_q >= LIM_L);
    // (L+1-n)/2 in output scaling: L*2^F minus the fraction of normalized z
    num      = {1'b0, l_q, {F{1'b0}}} - {{(LW+1){1'b0}}, z_q[F-1:0]};
    mag_full = num >> SH;
    over     = {{W_OUT{1'b0}}, mag_full} > {{NW{1'b0}}, POS_MAX};
    mag      = over ? POS_MAX : (W_OUT)'(mag_full);
  end

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    l_d     = l_q;
    sign_d  = sign_q;
    data_d  = data_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_data[W_IN-1];
          z_d     = ONE - abs_y;
          l_d     = '0;
          state_d = NORM;
        end
      end
      NORM: begin
        if (z_q[W_IN-1] || z_zero || (l_q == LIM_L)) begin
          state_d = CALC;
        end else begin
          z_d = z_q << 1;
          l_d = l_q + 1'b1;
        end
      end
      CALC: begin
        if (sat_c) begin
          data_d = sign_q ? -POS_MAX : POS_MAX;
          sat_d  = 1'b1;
        end else begin
          data_d = sign_q ? -mag : mag;
          sat_d  = over;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      z_q     <= '0;
      l_q     <= '0;
      sign_q  <= 1'b0;
      data_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      l_q     <= l_d;
      sign_q  <= sign_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_shift_pla_atanh.sv
// Bench for shift_pla_atanh: directed vector table, backpressure/reset sequences, random stream vs atanh-PLA model.
module tb_shift_pla_atanh;

  localparam int W_IN  = 16;
  localparam int W_OUT = 16;
  localparam int OUT_I = 4;
  localparam int SAT_K = 4;
  localparam int LIM   = 2 * SAT_K;
  localparam int NRAND = 1000;

  logic              clock = 1'b0;
  logic              resetn;
  logic [W_IN-1:0]   in_data;
  logic              in_valid;
  logic              in_ready;
  logic [W_OUT-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sat;

  int n_cmp = 0;
  int n_bad = 0;

  shift_pla_atanh #(.W_IN(W_IN), .W_OUT(W_OUT), .OUT_I(OUT_I), .SAT_K(SAT_K)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sat  (out_sat)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: |y| -> z = 1-|y|; L = leading zeros of z in Q1.15; x = ((L+1)*2^15 - z*2^L) / 2^4.
  function automatic void ref_model(input logic [15:0] y, output logic [15:0] d,
                                    output logic s, output int lat);
    int sg, a, z, k, l, mag;
    sg = int'(y[15]);
    a  = (sg != 0) ? 65536 - int'(y) : int'(y);
    z  = 32768 - a;
    if (z == 0) begin
      l = 0;
      s = 1'b1;
    end else begin
      k = $clog2(z + 1) - 1;
      l = 15 - k;
      s = (l >= LIM);
      if (l > LIM) l = LIM;
    end
    lat = l + 3;
    if (s) begin
      d = (sg != 0) ? 16'h8001 : 16'h7FFF;
    end else begin
      mag = ((l + 1) * 32768 - z * (1 << l)) / 16;
      if (mag > 32767) begin
        s   = 1'b1;
        mag = 32767;
      end
      d = (sg != 0) ? 16'(-mag) : 16'(mag);
    end
  endfunction

  function automatic logic [15:0] gen_y();
    logic [15:0] y;
    y = 16'($urandom);
    if ($urandom_range(1) == 0)
      y = {(($urandom_range(1) == 0) ? 8'h7F : 8'h80), 8'($urandom)};
    return y;
  endfunction

  task automatic run_one(input string nm, input logic [15:0] y, input logic [15:0] ed,
                         input logic es, input int el);
    int lat;
    int guard;
    guard     = 0;
    out_ready = 1'b1;
    while (!in_ready && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    in_data  = y;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    check({nm, " data"}, out_data, ed);
    check({nm, " sat"}, out_sat, es);
    check({nm, " lat"}, lat, el);
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic [15:0] y;
    logic [15:0] d;
    logic        s;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [15:0] q_d[$];
    logic        q_s[$];
    logic [15:0] md;
    logic        ms;
    int          mlat;
    int          sent, got, cyc, lat;
    logic        acc, stall_v, stall_s;
    logic [15:0] stall_d;

    vecs[0]  = '{16'h0000, 16'h0000, 1'b0, 3};
    vecs[1]  = '{16'h4000, 16'h0800, 1'b0, 4};
    vecs[2]  = '{16'h2000, 16'h0400, 1'b0, 4};
    vecs[3]  = '{16'h6000, 16'h1000, 1'b0, 5};
    vecs[4]  = '{16'hC000, 16'hF800, 1'b0, 4};
    vecs[5]  = '{16'h7F00, 16'h3800, 1'b0, 10};
    vecs[6]  = '{16'h7F80, 16'h7FFF, 1'b1, 11};
    vecs[7]  = '{16'h8000, 16'h8001, 1'b1, 3};
    vecs[8]  = '{16'h8100, 16'hC800, 1'b0, 10};
    vecs[9]  = '{16'hE000, 16'hFC00, 1'b0, 4};
    vecs[10] = '{16'h0001, 16'h0000, 1'b0, 4};

    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_data", out_data, 16'h0000);
    check("reset out_sat", out_sat, 1'b0);
    resetn = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 11; i++)
      run_one($sformatf("vec%0d", i), vecs[i].y, vecs[i].d, vecs[i].s, vecs[i].lat);

    // Backpressure: result held for 5 stalled cycles while a second operand waits.
    out_ready = 1'b0;
    in_data   = 16'h4000;
    in_valid  = 1'b1;
    @(posedge clock); #1;
    in_data = 16'h2000;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    check("bp first lat", lat, 4);
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid", out_valid, 1'b1);
      check("bp out_data", out_data, 16'h0800);
      check("bp out_sat", out_sat, 1'b0);
      check("bp in_ready", in_ready, 1'b0);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp release out_valid", out_valid, 1'b0);
    check("bp release in_ready", in_ready, 1'b1);
    @(posedge clock); #1;
    check("bp second accepted", in_ready, 1'b0);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    check("bp second data", out_data, 16'h0400);
    check("bp second lat", lat, 4);
    @(posedge clock); #1;

    // Reset while normalizing discards the operand.
    in_data  = 16'h7F00;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("mid busy in_ready", in_ready, 1'b0);
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    check("mid rst out_valid", out_valid, 1'b0);
    check("mid rst in_ready", in_ready, 1'b1);
    check("mid rst out_data", out_data, 16'h0000);
    run_one("post rst", 16'h4000, 16'h0800, 1'b0, 4);

    // Random stream with random consumer stalls.
    sent = 0; got = 0; cyc = 0;
    stall_v = 1'b0; stall_d = '0; stall_s = 1'b0;
    in_valid = 1'b0;
    while (got < NRAND && cyc < 40000) begin
      if (!in_valid && sent < NRAND && $urandom_range(3) != 0) begin
        in_data  = gen_y();
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(2) != 0);
      @(negedge clock);
      if (stall_v) begin
        check("hold out_valid", out_valid, 1'b1);
        check("hold out_data", out_data, stall_d);
        check("hold out_sat", out_sat, stall_s);
      end
      acc = in_valid && in_ready;
      if (acc) begin
        ref_model(in_data, md, ms, mlat);
        q_d.push_back(md);
        q_s.push_back(ms);
        sent++;
      end
      stall_v = out_valid && !out_ready;
      stall_d = out_data;
      stall_s = out_sat;
      if (out_valid && out_ready) begin
        if (q_d.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rand unexpected output: got 0x%0h with no operand pending", out_data);
        end else begin
          check($sformatf("rand%0d data", got), out_data, q_d.pop_front());
          check($sformatf("rand%0d sat", got), out_sat, q_s.pop_front());
        end
        got++;
      end
      @(posedge clock); #1;
      if (acc) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
      end
      cyc++;
    end
    check("rand results received", got, NRAND);
    check("rand pending left", q_d.size(), 0);
    out_ready = 1'b1;
    repeat (15) @(posedge clock);
    #1;
    check("rand no extra output", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
